// File: rtl/opmode_ctrl.sv
// opmode_ctrl: optionally registered DSP control word with change-settle tracking.
// Define OPMODE_DRC_EN to build the illegal-word checker (drc_err/drc_sticky); otherwise both are tied low.
module opmode_ctrl #(
   parameter int OPMODEREG  = 1,
   parameter int SETTLE_CYC = 2
) (
   input  logic       CLK,
   input  logic       RSTCTRL,
   input  logic       CECTRL,
   input  logic [6:0] OPMODE,
   input  logic [3:0] ALUMODE,
   input  logic [2:0] CARRYINSEL,
   output logic [3:0] xy_sel,
   output logic [2:0] z_sel,
   output logic [3:0] alu_op,
   output logic [2:0] carryin_sel,
   output logic       ctrl_settled,
   output logic       drc_err,
   output logic       drc_sticky
);
   logic [13:0] in_w, eff_w, prev_q;
   logic [3:0]  cnt_q, cnt_d;
   logic        change;
   assign in_w = {OPMODE, ALUMODE, CARRYINSEL};
   generate
      if (OPMODEREG != 0) begin : g_reg
         logic [13:0] ctrl_q, ctrl_d;
         assign ctrl_d = CECTRL ? in_w : ctrl_q;
         always_ff @(posedge CLK)
            ctrl_q <= RSTCTRL ? '0 : ctrl_d;
         assign eff_w = ctrl_q;
      end else begin : g_comb
         logic unused_ce;
         assign unused_ce = CECTRL;
         assign eff_w = in_w;
      end
   endgenerate
   assign xy_sel      = eff_w[10:7];
   assign z_sel       = eff_w[13:11];
   assign alu_op      = eff_w[6:3];
   assign carryin_sel = eff_w[2:0];
   // A change reloads the count even mid-settle, so it can never wrap.
   assign change = eff_w != prev_q;
   assign cnt_d  = change ? 4'(SETTLE_CYC) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0);
   always_ff @(posedge CLK) begin
      prev_q <= RSTCTRL ? '0 : eff_w;
      cnt_q  <= RSTCTRL ? '0 : cnt_d;
   end
   assign ctrl_settled = cnt_q == 4'd0;
`ifdef OPMODE_DRC_EN
   logic drc_sticky_q;
   always_comb
      drc_err = ((xy_sel[1:0] == 2'b01) ^ (xy_sel[3:2] == 2'b01)) | (z_sel == 3'b111) | (carryin_sel == 3'b111);
   always_ff @(posedge CLK)
      drc_sticky_q <= RSTCTRL ? 1'b0 : drc_sticky_q | drc_err;
   assign drc_sticky = drc_sticky_q;
`else
   assign drc_err    = 1'b0;
   assign drc_sticky = 1'b0;
`endif
endmodule

// File: doc/opmode_ctrl.md
OPMODE_CTRL -- requirements
Module: opmode_ctrl

Interface
REQ-001 Parameter OPMODEREG, default 1: 1 = control inputs registered; 0 = control inputs pass through combinationally.
REQ-002 Parameter SETTLE_CYC, default 2, range 1-15: cycles ctrl_settled stays low after a control change.
REQ-003 Port CLK, input, 1: single clock, rising edge.
REQ-004 Port RSTCTRL, input, 1: synchronous, active-high reset.
REQ-005 Port CECTRL, input, 1: clock enable for the control registers.
REQ-006 Port OPMODE, input, 7: [1:0] X select, [3:2] Y select, [6:4] Z select.
REQ-007 Port ALUMODE, input, 4: post-adder operation code.
REQ-008 Port CARRYINSEL, input, 3: carry-in source select.
REQ-009 Port xy_sel, output, 4: equals effective OPMODE[3:0]; drives the Y operand mux select (00xx = 0, 0101 = M, 10xx = all-ones, 11xx = C).
REQ-010 Port z_sel, output, 3: equals effective OPMODE[6:4].
REQ-011 Port alu_op, output, 4: equals effective ALUMODE.
REQ-012 Port carryin_sel, output, 3: equals effective CARRYINSEL.
REQ-013 Port ctrl_settled, output, 1: high when operand pipeline data matches the current control.
REQ-014 Port drc_err, output, 1: high while the effective control word is illegal.
REQ-015 Port drc_sticky, output, 1: latched OR of drc_err, held until reset.

Function
REQ-016 OPMODEREG=1: on a CLK edge with RSTCTRL=0 and CECTRL=1, load OPMODE, ALUMODE and CARRYINSEL into the control registers; with CECTRL=0, hold them.
REQ-017 OPMODEREG=1: outputs xy_sel, z_sel, alu_op and carryin_sel SHALL come from the registers, with 1-cycle latency from input to output.
REQ-018 OPMODEREG=0: those outputs SHALL follow the inputs combinationally, with 0 latency; CECTRL is ignored.
REQ-019 Change detect: the effective control word is {OPMODE, ALUMODE, CARRYINSEL} after optional registration; a change is any difference between it and its value one cycle earlier.
REQ-020 Settle counter: on a change, load SETTLE_CYC and drive ctrl_settled=0; decrement each cycle; ctrl_settled=1 when the count is 0.
REQ-021 A change while the count is nonzero SHALL reload SETTLE_CYC, so the counter never wraps below 0.
REQ-022 A change and a counter expiry in the same cycle: the reload wins.
REQ-023 DRC rule A: exactly one of X select (OPMODE[1:0]) and Y select (OPMODE[3:2]) equals 01 -> illegal.
REQ-024 DRC rule B: Z select = 111 -> illegal.
REQ-025 DRC rule C: CARRYINSEL = 111 -> illegal.
REQ-026 drc_err SHALL be combinational from the effective control word; drc_sticky SHALL set on the cycle after drc_err is high.
REQ-027 Illegal words SHALL still pass to the outputs unmodified; the block only flags them.

Reset
REQ-028 With RSTCTRL=1 at a CLK edge: control registers = 0, settle count = 0, drc_sticky = 0.
REQ-029 After reset (OPMODEREG=1): xy_sel=0, z_sel=0, alu_op=0, carryin_sel=0, ctrl_settled=1, drc_err=0.
REQ-030 Reset mid-settle SHALL abort the count; ctrl_settled=1 on the next cycle.
REQ-031 RSTCTRL SHALL override CECTRL.
REQ-032 After reset, the previous-word register SHALL be 0, so a first nonzero load counts as a change.

Configuration
REQ-033 Macro OPMODE_DRC_EN defined: REQ-023 to REQ-026 are implemented.
REQ-034 Macro OPMODE_DRC_EN undefined: drc_err and drc_sticky are tied to 0, and no checker logic is synthesized.

Verification
REQ-035 OPMODEREG=1, CECTRL=1, OPMODE=7'b0110101 -> next cycle xy_sel=4'b0101, z_sel=3'b011.
REQ-036 CECTRL=0 with OPMODE changed to 7'h0C -> outputs hold the previous value and ctrl_settled stays 1.
REQ-037 SETTLE_CYC=2, ALUMODE 0->3 -> ctrl_settled low for exactly 2 cycles; a second change after 1 cycle extends the low time to 3 cycles total.
REQ-038 With OPMODE_DRC_EN defined, OPMODE=7'b0000001 -> drc_err=1, then drc_sticky=1 on the next cycle and remaining 1 after OPMODE=0.
REQ-039 RSTCTRL pulsed mid-settle with OPMODE=7'h7F loaded -> all outputs 0, ctrl_settled=1, drc_sticky=0 after the reset edge.
REQ-040 OPMODEREG=0, OPMODE=7'b0001100 -> xy_sel=4'b1100 in the same cycle.
